// File: rtl/axi_memory_if.sv
// AXI4 bus bundle for axi_memory: write address/data/response and read address/data channels.
interface axi_memory_if #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ID_WIDTH      = 1
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]      aw_id;
    logic [ADDRESS_WIDTH-1:0] aw_addr;
    logic [7:0]               aw_len;
    logic [2:0]               aw_size;
    logic [1:0]               aw_burst;
    logic [3:0]               aw_cache;
    logic [2:0]               aw_prot;
    logic [3:0]               aw_qos;
    logic [3:0]               aw_region;
    logic                     aw_valid;
    logic                     aw_ready;

    logic [DATA_WIDTH-1:0]    w_data;
    logic [STRB_WIDTH-1:0]    w_strb;
    logic                     w_last;
    logic                     w_valid;
    logic                     w_ready;

    logic [ID_WIDTH-1:0]      b_id;
    logic [1:0]               b_resp;
    logic                     b_valid;
    logic                     b_ready;

    logic [ID_WIDTH-1:0]      ar_id;
    logic [ADDRESS_WIDTH-1:0] ar_addr;
    logic [7:0]               ar_len;
    logic [2:0]               ar_size;
    logic [1:0]               ar_burst;
    logic [3:0]               ar_cache;
    logic [2:0]               ar_prot;
    logic [3:0]               ar_qos;
    logic [3:0]               ar_region;
    logic                     ar_valid;
    logic                     ar_ready;

    logic [ID_WIDTH-1:0]      r_id;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [1:0]               r_resp;
    logic                     r_last;
    logic                     r_valid;
    logic                     r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_region, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_region, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_region, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_region, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_memory.sv
// AXI4 slave RAM model: one write burst and one read burst in flight, channels independent.
// Out-of-range beats are dropped (write) or return zero (read) and flag SLVERR.
module axi_memory #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ID_WIDTH      = 1,
    parameter int unsigned MEM_DEPTH     = 1024
) (
    input logic         clk,
    input logic         rst,
    axi_memory_if.slave bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int unsigned WORD_BITS  = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] MEM_BYTES = (ADDRESS_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t                 state;
    logic [3:0]               outstandaing_w;
    logic [ID_WIDTH-1:0]      w_id_q;
    logic [ADDRESS_WIDTH-1:0] w_addr_q;
    logic [7:0]               w_len_q;
    logic [2:0]               w_size_q;
    logic [1:0]               w_burst_q;
    logic [7:0]               w_beat_q;
    logic                     w_err_q;
    logic                     w_fire;
    logic                     w_beat_err;

    r_state_t                 r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr_q;
    logic [7:0]               r_len_q;
    logic [2:0]               r_size_q;
    logic [1:0]               r_burst_q;
    logic [7:0]               r_beat_q;
    logic                     r_size_err_q;

    logic unused_sideband;
    assign unused_sideband = ^{bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region,
                               bus.ar_cache, bus.ar_prot, bus.ar_qos, bus.ar_region};

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] addr);
        return {1'b0, addr} < MEM_BYTES;
    endfunction

    function automatic logic [WORD_BITS-1:0] word_of(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr[ADDR_LSB +: WORD_BITS];
    endfunction

    function automatic logic size_bad(input logic [2:0] size);
        return 32'(size) > ADDR_LSB;
    endfunction

    // WRAP is deliberately handled like INCR; only FIXED holds the address.
    function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] addr,
                                                           input logic [2:0] size,
                                                           input logic [1:0] burst);
        return (burst == BURST_FIXED) ? addr : addr + (ADDRESS_WIDTH'(1) << size);
    endfunction

    assign w_fire     = (state == W_DATA) && bus.w_valid && bus.w_ready;
    assign w_beat_err = !in_range(w_addr_q) || (bus.w_last && (w_beat_q != w_len_q));

    // RAM has no reset; reads in the same cycle see the pre-write word.
    always_ff @(posedge clk) begin
        if (w_fire && in_range(w_addr_q)) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (bus.w_strb[i]) begin
                    mem[word_of(w_addr_q)][i*8 +: 8] <= bus.w_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= W_IDLE;
            outstandaing_w <= '0;
            bus.aw_ready   <= 1'b0;
            bus.w_ready    <= 1'b0;
            bus.b_valid    <= 1'b0;
            bus.b_id       <= '0;
            bus.b_resp     <= '0;
            w_id_q         <= '0;
            w_addr_q       <= '0;
            w_len_q        <= '0;
            w_size_q       <= '0;
            w_burst_q      <= '0;
            w_beat_q       <= '0;
            w_err_q        <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    bus.aw_ready <= 1'b1;
                    if (bus.aw_valid && bus.aw_ready) begin
                        w_id_q       <= bus.aw_id;
                        w_addr_q     <= bus.aw_addr;
                        w_len_q      <= bus.aw_len;
                        w_size_q     <= bus.aw_size;
                        w_burst_q    <= bus.aw_burst;
                        w_beat_q     <= '0;
                        w_err_q      <= size_bad(bus.aw_size);
                        if (outstandaing_w != 4'd15) begin
                            outstandaing_w <= outstandaing_w + 4'd1;
                        end
                        bus.aw_ready <= 1'b0;
                        bus.w_ready  <= 1'b1;
                        state        <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
                        w_beat_q <= w_beat_q + 8'd1;
                        w_err_q  <= w_err_q | w_beat_err;
                        if (bus.w_last) begin
                            bus.w_ready <= 1'b0;
                            bus.b_valid <= 1'b1;
                            bus.b_id    <= w_id_q;
                            bus.b_resp  <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state       <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.b_valid && bus.b_ready) begin
                        bus.b_valid <= 1'b0;
                        if (outstandaing_w != 4'd0) begin
                            outstandaing_w <= outstandaing_w - 4'd1;
                        end
                        bus.aw_ready <= 1'b1;
                        state        <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= R_IDLE;
            bus.ar_ready <= 1'b0;
            bus.r_valid  <= 1'b0;
            bus.r_id     <= '0;
            bus.r_data   <= '0;
            bus.r_resp   <= '0;
            bus.r_last   <= 1'b0;
            r_addr_q     <= '0;
            r_len_q      <= '0;
            r_size_q     <= '0;
            r_burst_q    <= '0;
            r_beat_q     <= '0;
            r_size_err_q <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    bus.ar_ready <= 1'b1;
                    if (bus.ar_valid && bus.ar_ready) begin
                        r_len_q      <= bus.ar_len;
                        r_size_q     <= bus.ar_size;
                        r_burst_q    <= bus.ar_burst;
                        r_size_err_q <= size_bad(bus.ar_size);
                        r_beat_q     <= '0;
                        r_addr_q     <= next_addr(bus.ar_addr, bus.ar_size, bus.ar_burst);
                        bus.r_id     <= bus.ar_id;
                        bus.r_data   <= in_range(bus.ar_addr) ? mem[word_of(bus.ar_addr)] : '0;
                        bus.r_resp   <= (!in_range(bus.ar_addr) || size_bad(bus.ar_size)) ?
                                        RESP_SLVERR : RESP_OKAY;
                        bus.r_last   <= (bus.ar_len == 8'd0);
                        bus.r_valid  <= 1'b1;
                        bus.ar_ready <= 1'b0;
                        r_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.r_valid && bus.r_ready) begin
                        if (bus.r_last) begin
                            bus.r_valid  <= 1'b0;
                            bus.r_last   <= 1'b0;
                            bus.ar_ready <= 1'b1;
                            r_state      <= R_IDLE;
                        end else begin
                            r_beat_q   <= r_beat_q + 8'd1;
                            r_addr_q   <= next_addr(r_addr_q, r_size_q, r_burst_q);
                            bus.r_data <= in_range(r_addr_q) ? mem[word_of(r_addr_q)] : '0;
                            bus.r_resp <= (!in_range(r_addr_q) || r_size_err_q) ? RESP_SLVERR : RESP_OKAY;
                            bus.r_last <= ((r_beat_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_memory.sv
// Self-checking bench for axi_memory: byte-level memory model plus per-cycle channel scoreboard.
module tb_axi_memory;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 1;
    localparam int unsigned DEPTH = 1024;
    localparam longint unsigned MEM_BYTES = DEPTH * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_memory_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) bus();

    axi_memory #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [0:0] id; } r_exp_t;
    typedef struct { logic [1:0] resp; logic [0:0] id; } b_exp_t;

    r_exp_t      r_q [$];
    b_exp_t      b_q [$];
    logic [63:0] got_r [$];
    logic [1:0]  got_b [$];
    logic [63:0] model_mem [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [3:0]  bumped;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic hs(input int unsigned which);
        case (which)
            0: return bus.aw_ready;
            1: return bus.w_ready;
            2: return bus.b_valid && bus.b_ready;
            3: return bus.ar_ready;
            4: return bus.r_valid && bus.r_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hs(input int unsigned which, input string nm);
        int unsigned guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!hs(which) && guard < 100);
        if (!hs(which)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no handshake within %0d cycles", nm, guard);
        end
    endtask

    function automatic longint unsigned adv(input longint unsigned a, input logic [2:0] size,
                                            input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (longint'(1) << size);
    endfunction

    // Scoreboard: every cycle a response is valid it must match the head expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.r_valid) begin
                if (r_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL r_spurious: r_valid=1 with no read outstanding");
                end else begin
                    check("r_data", bus.r_data, r_q[0].data);
                    check("r_resp", 64'(bus.r_resp), 64'(r_q[0].resp));
                    check("r_last", 64'(bus.r_last), 64'(r_q[0].last));
                    check("r_id", 64'(bus.r_id), 64'(r_q[0].id));
                    if (bus.r_ready) begin
                        got_r.push_back(bus.r_data);
                        void'(r_q.pop_front());
                    end
                end
            end
            if (bus.b_valid) begin
                if (b_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_spurious: b_valid=1 with no write outstanding");
                end else begin
                    check("b_resp", 64'(bus.b_resp), 64'(b_q[0].resp));
                    check("b_id", 64'(bus.b_id), 64'(b_q[0].id));
                    if (bus.b_ready) begin
                        got_b.push_back(bus.b_resp);
                        void'(b_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [0:0] id, input longint unsigned addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int unsigned nbeats, input int unsigned gaps);
        longint unsigned a = addr;
        logic err = (size > 3'd3);
        b_exp_t e;
        @(posedge clk); #1;
        bus.aw_id = id; bus.aw_addr = AW'(addr); bus.aw_len = len; bus.aw_size = size;
        bus.aw_burst = burst; bus.aw_cache = 4'($urandom); bus.aw_prot = 3'($urandom);
        bus.aw_qos = 4'($urandom); bus.aw_region = 4'($urandom); bus.aw_valid = 1'b1;
        wait_hs(0, "aw_hs");
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        @(negedge clk);
        check("outst_after_aw", 64'(dut.outstandaing_w), 64'd1);
        for (int unsigned k = 0; k < nbeats; k++) begin
            @(posedge clk); #1;
            bus.w_valid = 1'b0;
            repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
            bus.w_data = wd[k]; bus.w_strb = ws[k]; bus.w_last = (k == nbeats - 1); bus.w_valid = 1'b1;
            wait_hs(1, "w_hs");
            if (a < MEM_BYTES) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (ws[k][i]) model_mem[a / 8][i*8 +: 8] = wd[k][i*8 +: 8];
                end
            end else begin
                err = 1'b1;
            end
            a = adv(a, size, burst);
        end
        if (nbeats - 1 != 32'(len)) err = 1'b1;
        e.resp = err ? 2'b10 : 2'b00;
        e.id = id;
        b_q.push_back(e);
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        bus.w_last = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.b_ready = 1'b1;
        wait_hs(2, "b_hs");
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        @(negedge clk);
        check("outst_after_b", 64'(dut.outstandaing_w), 64'd0);
    endtask

    task automatic do_read(input logic [0:0] id, input longint unsigned addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int hold);
        longint unsigned a = addr;
        for (int unsigned k = 0; k <= 32'(len); k++) begin
            r_exp_t e;
            e.data = (a < MEM_BYTES) ? model_mem[a / 8] : 64'd0;
            e.resp = (a >= MEM_BYTES || size > 3'd3) ? 2'b10 : 2'b00;
            e.last = (k == 32'(len));
            e.id = id;
            r_q.push_back(e);
            a = adv(a, size, burst);
        end
        @(posedge clk); #1;
        bus.ar_id = id; bus.ar_addr = AW'(addr); bus.ar_len = len; bus.ar_size = size;
        bus.ar_burst = burst; bus.ar_cache = 4'($urandom); bus.ar_prot = 3'($urandom);
        bus.ar_qos = 4'($urandom); bus.ar_region = 4'($urandom); bus.ar_valid = 1'b1;
        wait_hs(3, "ar_hs");
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        for (int unsigned k = 0; k <= 32'(len); k++) begin
            bus.r_ready = 1'b0;
            repeat ((hold >= 0) ? hold : int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
            bus.r_ready = 1'b1;
            wait_hs(4, "r_hs");
            @(posedge clk); #1;
        end
        bus.r_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (model_mem[i]) model_mem[i] = '0;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
        bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
        bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        // Reset: outputs quiet while asserted, both address channels ready afterwards.
        #1 rst = 1'b0;
        #7;
        check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        check("rst_w_ready", 64'(bus.w_ready), 64'd0);
        check("rst_b_valid", 64'(bus.b_valid), 64'd0);
        check("rst_b_id", 64'(bus.b_id), 64'd0);
        check("rst_b_resp", 64'(bus.b_resp), 64'd0);
        check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        check("rst_r_valid", 64'(bus.r_valid), 64'd0);
        check("rst_r_data", bus.r_data, 64'd0);
        check("rst_r_last", 64'(bus.r_last), 64'd0);
        check("rst_r_id", 64'(bus.r_id), 64'd0);
        check("rst_r_resp", 64'(bus.r_resp), 64'd0);
        check("rst_state", 64'(dut.state), 64'd0);
        check("rst_outst", 64'(dut.outstandaing_w), 64'd0);
        #3 rst = 1'b1;
        @(negedge clk);
        check("post_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        check("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);
        check("post_rst_state", 64'(dut.state), 64'd0);

        // Zero the whole RAM so the model's all-zero start is established.
        for (int unsigned k = 0; k < 256; k++) begin wd[k] = '0; ws[k] = 8'hFF; end
        for (int unsigned blk = 0; blk < 4; blk++) do_write(1'b0, blk * 2048, 8'd255, 3'd3, 2'b01, 256, 0);

        // Single-beat write/read.
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(1'b1, 0, 8'd0, 3'd3, 2'b01, 1, 0);
        check("t2_b_resp", 64'(got_b[$]), 64'd0);
        check("t2_model", model_mem[0], 64'h1122334455667788);
        got_r.delete();
        do_read(1'b0, 0, 8'd0, 3'd3, 2'b01, -1);
        check("t2_r_data", got_r[0], 64'h1122334455667788);

        // INCR burst with a partial strobe, read back under backpressure.
        wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'd3; wd[3] = 64'd4;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'h0F; ws[3] = 8'hFF;
        do_write(1'b0, 64'h40, 8'd3, 3'd3, 2'b01, 4, 1);
        got_r.delete();
        do_read(1'b1, 64'h40, 8'd3, 3'd3, 2'b01, 3);
        check("t3_beats", 64'(got_r.size()), 64'd4);
        check("t3_beat0", got_r[0], 64'd1);
        check("t3_beat1", got_r[1], 64'd2);
        check("t3_beat2", got_r[2], 64'd3);
        check("t3_beat3", got_r[3], 64'd4);

        // Out-of-range access and other error cases.
        wd[0] = 64'hDEADBEEFCAFEF00D; ws[0] = 8'hFF;
        do_write(1'b1, MEM_BYTES, 8'd0, 3'd3, 2'b01, 1, 0);
        check("t4_b_resp", 64'(got_b[$]), 64'd2);
        got_r.delete();
        do_read(1'b0, MEM_BYTES, 8'd0, 3'd3, 2'b01, -1);
        do_read(1'b0, 0, 8'd0, 3'd3, 2'b01, -1);
        check("t4_oor_data", got_r[0], 64'd0);
        check("t4_word0_kept", got_r[1], 64'h1122334455667788);
        do_write(1'b1, 64'h100, 8'd0, 3'd4, 2'b01, 1, 0);
        check("size_err_b_resp", 64'(got_b[$]), 64'd2);
        do_write(1'b0, 64'h200, 8'd1, 3'd3, 2'b01, 1, 0);
        check("early_last_b_resp", 64'(got_b[$]), 64'd2);
        do_write(1'b0, 64'h300, 8'd1, 3'd3, 2'b01, 3, 0);
        check("late_last_b_resp", 64'(got_b[$]), 64'd2);
        do_read(1'b1, 64'h300, 8'd2, 3'd3, 2'b01, -1);

        // Randomised bursts: sizes, FIXED/INCR/WRAP, boundary crossings, bad lengths.
        repeat (40) begin
            longint unsigned addr;
            logic [7:0] len;
            logic [2:0] size;
            logic [1:0] burst;
            int unsigned nb;
            len = 8'($urandom_range(0, 7));
            size = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 7) == 0) ? MEM_BYTES - $urandom_range(0, 32)
                                               : longint'($urandom_range(0, 32'(MEM_BYTES) - 1));
            nb = ($urandom_range(0, 7) == 0) ? 32'(len) + 2 : 32'(len) + 1;
            for (int unsigned k = 0; k < nb; k++) begin
                wd[k] = {$urandom, $urandom};
                ws[k] = 8'($urandom);
            end
            do_write(1'($urandom), addr, len, size, burst, nb, 2);
            if ($urandom_range(0, 1) == 0) addr = longint'($urandom_range(0, 32'(MEM_BYTES) + 64));
            do_read(1'($urandom), addr, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 4)),
                    2'($urandom_range(0, 2)), -1);
        end

        // Repeated AW pulses with no W data, counter poke, then reset mid-burst.
        @(posedge clk); #1;
        bus.aw_id = 1'b0; bus.aw_addr = 32'h80; bus.aw_len = 8'd0; bus.aw_size = 3'd3; bus.aw_burst = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus.aw_valid = 1'b1;
            @(posedge clk); #1;
            bus.aw_valid = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t5_state", 64'(dut.state), 64'd1);
        check("t5_aw_ready", 64'(bus.aw_ready), 64'd0);
        check("t5_outst", 64'(dut.outstandaing_w), 64'd1);
        bumped = dut.outstandaing_w + 4'd1;
        force dut.outstandaing_w = bumped;
        @(negedge clk);
        check("t5_outst_forced", 64'(dut.outstandaing_w), 64'd2);
        check("t5_state_forced", 64'(dut.state), 64'd1);
        check("t5_aw_ready_forced", 64'(bus.aw_ready), 64'd0);
        release dut.outstandaing_w;
        rst = 1'b0;
        #2;
        check("t5_rst_outst", 64'(dut.outstandaing_w), 64'd0);
        check("t5_rst_state", 64'(dut.state), 64'd0);
        check("t5_rst_w_ready", 64'(bus.w_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_after_state", 64'(dut.state), 64'd0);
        check("t5_after_aw_ready", 64'(bus.aw_ready), 64'd1);
        check("t5_after_b_valid", 64'(bus.b_valid), 64'd0);
        check("t5_pending_b", 64'(b_q.size()), 64'd0);
        check("t5_pending_r", 64'(r_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
